pg_serial_adder: RTL

//   Multi-cycle add/subtract unit for the calculator datapath.

---
 rtl/pg_serial_adder_pkg.sv | 25 ++
 rtl/pg_serial_adder_pg_group.sv | 60 ++++++
 rtl/pg_serial_adder.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pg_serial_adder_pkg.sv
// Shared definitions for the chunked propagate/generate serial adder:
// FSM state encoding and the width helper used to size the chunk counter.
package pg_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Smallest r with 2**r >= value; clog2_f(1) is 0.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pg_serial_adder_pg_group.sv
// One GROUP-bit adder slice: per-bit half-adder propagate/generate cells,
// sum-of-products lookahead carries, and group P/G for a future carry tree.
module pg_group
    import pg_serial_adder_pkg::*;
#(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             c_msb,
    output logic             grp_p,
    output logic             grp_g
);

    logic [GROUP-1:0] p_s;
    logic [GROUP-1:0] g_s;
    logic [GROUP:0]   c_s;
    logic             grp_g_s;

    for (genvar i = 0; i < GROUP; i++) begin : gen_ha
        assign p_s[i] = a[i] ^ b[i];
        assign g_s[i] = a[i] & b[i];
    end

    // Lookahead carries: each c[i+1] is a flat OR of generate terms gated by
    // the propagate run above them, so no carry depends on another carry.
    always_comb begin
        logic term_v;
        logic prop_v;
        c_s     = {(GROUP+1){1'b0}};
        grp_g_s = 1'b0;
        term_v  = 1'b0;
        prop_v  = 1'b1;
        c_s[0]  = cin;
        for (int i = 0; i < GROUP; i++) begin
            term_v = 1'b0;
            prop_v = 1'b1;
            for (int j = i; j >= 0; j--) begin
                term_v = term_v | (prop_v & g_s[j]);
                prop_v = prop_v & p_s[j];
            end
            if (i == GROUP - 1) begin
                grp_g_s = term_v;
            end else begin
                grp_g_s = grp_g_s;
            end
            c_s[i+1] = term_v | (prop_v & cin);
        end
    end

    assign s     = p_s ^ c_s[GROUP-1:0];
    assign cout  = c_s[GROUP];
    assign c_msb = c_s[GROUP-1];
    assign grp_p = &p_s;
    assign grp_g = grp_g_s;

endmodule

// File: rtl/pg_serial_adder.sv
// Multi-cycle add/subtract: walks the operands GROUP bits per clock, LSB chunk
// first, and publishes sum/flags only once the whole word is complete.
module pg_serial_adder
    import pg_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int N  = WIDTH / GROUP;
    localparam int CW = clog2_f(N) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    if ((GROUP < 1) || (GROUP > WIDTH) || ((WIDTH % GROUP) != 0)) begin : g_bad_cfg
        $error("pg_serial_adder: GROUP must divide WIDTH and lie in 1..WIDTH");
    end

    state_e           state_r;
    state_e           state_nx_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] work_r;
    logic [WIDTH-1:0] work_nx_s;
    logic [CW-1:0]    idx_r;
    logic             carry_r;
    logic             carry_nx_s;
    logic             last_s;
    logic [GROUP-1:0] chunk_s;
    logic             grp_cout_s;
    logic             grp_cmsb_s;
    logic             grp_p_s;
    logic             grp_g_s;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             zero_r;

    // Operand registers shift right each RUN cycle, so the active chunk is
    // always the low GROUP bits.
    pg_group #(.GROUP(GROUP)) u_group (
        .a     (a_r[GROUP-1:0]),
        .b     (b_r[GROUP-1:0]),
        .cin   (carry_r),
        .s     (chunk_s),
        .cout  (grp_cout_s),
        .c_msb (grp_cmsb_s),
        .grp_p (grp_p_s),
        .grp_g (grp_g_s)
    );

    // Chunk bookkeeping: last-chunk detect, next working word, group carry.
    always_comb begin
        last_s     = (idx_r == LAST_IDX);
        work_nx_s  = WIDTH'({chunk_s, work_r} >> GROUP);
        carry_nx_s = grp_g_s | (grp_p_s & carry_r);
    end

    // Next-state logic for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= (state_nx_s == ST_DONE);
        end
    end

    // Operand capture and per-chunk datapath; subtraction enters as a + ~b + 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            work_r  <= {WIDTH{1'b0}};
            idx_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b ^ {WIDTH{sub}};
                        carry_r <= sub;
                        idx_r   <= {CW{1'b0}};
                    end else begin
                        carry_r <= carry_r;
                    end
                end
                ST_RUN: begin
                    a_r     <= a_r >> GROUP;
                    b_r     <= b_r >> GROUP;
                    work_r  <= work_nx_s;
                    carry_r <= carry_nx_s;
                    idx_r   <= idx_r + CW'(1);
                end
                default: begin
                    carry_r <= carry_r;
                end
            endcase
        end
    end

    // Result registers load only with the final chunk, hiding partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r  <= {WIDTH{1'b0}};
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if ((state_r == ST_RUN) && last_s) begin
            sum_r  <= work_nx_s;
            cout_r <= grp_cout_s;
            ovf_r  <= grp_cmsb_s ^ grp_cout_s;
            zero_r <= (work_nx_s == {WIDTH{1'b0}});
        end else begin
            sum_r  <= sum_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;
    assign ovf  = ovf_r;
    assign zero = zero_r;

endmodule
